// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use stall, flush squash and saturating stall counter
module id_ex_hazard_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic [3:0]       id_ALUOp,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [WIDTH-1:0] id_pc,
  input  logic             flush,
  output logic             ex_valid,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic [3:0]       ex_ALUOp,
  output logic [WIDTH-1:0] ex_rd1,
  output logic [WIDTH-1:0] ex_rd2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [WIDTH-1:0] ex_pc,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);
  logic hazard;
  assign hazard = id_valid & ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));
  assign stall = hazard & ~flush & ~reset;
  // pipeline register: reset, flush and load-use all insert a cleared bubble, otherwise load from ID
  always_ff @(posedge clk) begin
    if (reset || flush || hazard) begin
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUOp    <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_RegWrite <= id_valid & id_RegWrite;
      ex_MemRead  <= id_valid & id_MemRead;
      ex_MemWrite <= id_valid & id_MemWrite;
      ex_ALUOp    <= id_valid ? id_ALUOp : 4'd0;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
    end
  end
  // count bubbles caused by unflushed load-use hazards, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) stall_count <= '0;
    else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: scoreboard bench for the ID/EX register and load-use hazard logic
module tb_id_ex_hazard_stage;
  logic clk, reset, id_valid, id_use_rs2, id_RegWrite, id_MemRead, id_MemWrite, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_ALUOp;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
  logic ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, stall;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_ALUOp;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [3:0] stall_count;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic v;
    logic [4:0] rs1, rs2, rd;
    logic rw, mr, mw;
    logic [3:0] alu;
    logic [31:0] rd1, rd2, imm, pc;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];

  id_ex_hazard_stage #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_ALUOp(id_ALUOp), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_pc(id_pc), .flush(flush), .ex_valid(ex_valid), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_ALUOp(ex_ALUOp), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .stall(stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bub(input logic [3:0] cnt);
    exp_t e;
    e = '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, alu: 4'd0,
          rd1: 32'd0, rd2: 32'd0, imm: 32'd0, pc: 32'd0, cnt: cnt};
    return e;
  endfunction

  function automatic exp_t from_id(input logic [3:0] cnt);
    exp_t e;
    e = '{v: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd, rw: id_valid & id_RegWrite,
          mr: id_valid & id_MemRead, mw: id_valid & id_MemWrite, alu: id_valid ? id_ALUOp : 4'd0,
          rd1: id_rd1, rd2: id_rd2, imm: id_imm, pc: id_pc, cnt: cnt};
    return e;
  endfunction

  task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic [3:0] alu, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs2 = use2; id_rd = rd;
    id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw; id_ALUOp = alu;
    id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_pc = pc;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, ex_valid, e.v);
      chk({tag, "_rs1"}, ex_rs1, e.rs1);
      chk({tag, "_rs2"}, ex_rs2, e.rs2);
      chk({tag, "_rd"}, ex_rd, e.rd);
      chk({tag, "_RegWrite"}, ex_RegWrite, e.rw);
      chk({tag, "_MemRead"}, ex_MemRead, e.mr);
      chk({tag, "_MemWrite"}, ex_MemWrite, e.mw);
      chk({tag, "_ALUOp"}, ex_ALUOp, e.alu);
      chk({tag, "_rd1"}, ex_rd1, e.rd1);
      chk({tag, "_rd2"}, ex_rd2, e.rd2);
      chk({tag, "_imm"}, ex_imm, e.imm);
      chk({tag, "_pc"}, ex_pc, e.pc);
      chk({tag, "_stall_count"}, stall_count, e.cnt);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    chk(tag, stall, exp);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    flush = 1'b0;
    id_set(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 4'd1, 32'hA, 32'hB, 32'hC, 32'hD);
    q.push_back(bub(4'd0));
    tick("reset1");
    chk_stall("reset_stall", 1'b0);
    q.push_back(bub(4'd0));
    tick("reset2");
    reset = 1'b0;
    id_set(1, 5'd3, 5'd4, 1, 5'd5, 1, 0, 0, 4'd2, 32'h11, 32'h22, 32'hFFFF_FFF0, 32'h100);
    chk_stall("pass_stall", 1'b0);
    q.push_back('{v: 1'b1, rs1: 5'd3, rs2: 5'd4, rd: 5'd5, rw: 1'b1, mr: 1'b0, mw: 1'b0, alu: 4'd2,
                  rd1: 32'h11, rd2: 32'h22, imm: 32'hFFFF_FFF0, pc: 32'h100, cnt: 4'd0});
    tick("pass");
    id_set(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, 0, 4'd0, 32'h40, 32'h0, 32'h8, 32'h104);
    chk_stall("lw_stall", 1'b0);
    q.push_back(from_id(4'd0));
    tick("lw");
    id_set(1, 5'd5, 5'd6, 1, 5'd7, 1, 0, 0, 4'd2, 32'h55, 32'h66, 32'h0, 32'h108);
    chk_stall("use_stall", 1'b1);
    q.push_back(bub(4'd1));
    tick("use_bubble");
    chk_stall("use_release", 1'b0);
    q.push_back('{v: 1'b1, rs1: 5'd5, rs2: 5'd6, rd: 5'd7, rw: 1'b1, mr: 1'b0, mw: 1'b0, alu: 4'd2,
                  rd1: 32'h55, rd2: 32'h66, imm: 32'h0, pc: 32'h108, cnt: 4'd1});
    tick("use_proceed");
    id_set(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, 0, 4'd0, 32'h40, 32'h0, 32'h4, 32'h10C);
    q.push_back(from_id(4'd1));
    tick("lw2");
    id_set(1, 5'd1, 5'd5, 0, 5'd0, 1, 1, 0, 4'd0, 32'h1, 32'h2, 32'h0, 32'h110);
    chk_stall("no_use_rs2", 1'b0);
    id_use_rs2 = 1'b1;
    chk_stall("use_rs2_hit", 1'b1);
    id_use_rs2 = 1'b0;
    chk_stall("no_use_rs2_again", 1'b0);
    q.push_back(from_id(4'd1));
    tick("lw_x0");
    id_set(1, 5'd0, 5'd0, 1, 5'd9, 1, 0, 0, 4'd3, 32'h3, 32'h4, 32'h5, 32'h114);
    chk_stall("x0_stall", 1'b0);
    q.push_back(from_id(4'd1));
    tick("after_x0");
    id_set(0, 5'd2, 5'd3, 1, 5'd4, 1, 1, 1, 4'd7, 32'h77, 32'h88, 32'h99, 32'h118);
    q.push_back('{v: 1'b0, rs1: 5'd2, rs2: 5'd3, rd: 5'd4, rw: 1'b0, mr: 1'b0, mw: 1'b0, alu: 4'd0,
                  rd1: 32'h77, rd2: 32'h88, imm: 32'h99, pc: 32'h118, cnt: 4'd1});
    tick("invalid");
    id_set(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, 0, 4'd0, 32'h40, 32'h0, 32'h0, 32'h11C);
    q.push_back(from_id(4'd1));
    tick("lw3");
    id_set(1, 5'd5, 5'd0, 0, 5'd8, 1, 0, 0, 4'd2, 32'h1, 32'h1, 32'h1, 32'h120);
    flush = 1'b1;
    chk_stall("flush_stall", 1'b0);
    q.push_back(bub(4'd1));
    tick("flush");
    flush = 1'b0;
    id_set(1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 4'd0, 32'h5, 32'h0, 32'h0, 32'h200);
    c = 1;
    for (int i = 0; i < 17; i++) begin
      chk_stall("sat_nostall", 1'b0);
      q.push_back(from_id(4'(c)));
      tick("sat_load");
      chk_stall("sat_stall", 1'b1);
      c = (c < 15) ? c + 1 : 15;
      q.push_back(bub(4'(c)));
      tick("sat_bubble");
    end
    chk("sat_final", stall_count, 32'd15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core. It captures decoded operands and control from ID and presents them to EX. The EX-side register addresses it presents (ex_rs1, ex_rs2) are the Addr1/Addr2 operands consumed by the downstream forwarding unit. It stalls IF/ID and injects a bubble when a load result cannot be forwarded in time, squashes on taken branch, and keeps a saturating stall counter.

Parameters:
WIDTH, 32, datapath width of operand, immediate and PC fields
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_rs1  input  5  source register 1 address
id_rs2  input  5  source register 2 address
id_use_rs2  input  1  instruction reads rs2 (R-type, store, branch)
id_rd  input  5  destination register address
id_RegWrite  input  1  writes register file
id_MemRead  input  1  load instruction
id_MemWrite  input  1  store instruction
id_ALUOp  input  4  ALU control
id_rd1  input  WIDTH  register file read data 1
id_rd2  input  WIDTH  register file read data 2
id_imm  input  WIDTH  sign-extended immediate
id_pc  input  WIDTH  instruction PC
flush  input  1  taken branch/jump resolved in EX; squash ID contents
ex_valid  output  1  EX holds a real instruction
ex_rs1, ex_rs2, ex_rd  output  5 each  registered addresses (ex_rs1/ex_rs2 drive forwarding unit Addr1/Addr2)
ex_RegWrite, ex_MemRead, ex_MemWrite  output  1 each  registered control
ex_ALUOp  output  4  registered ALU control
ex_rd1, ex_rd2, ex_imm, ex_pc  output  WIDTH each  registered data
stall  output  1  combinational; hold PC and IF/ID register this cycle
stall_count  output  CNT_W  number of bubbles inserted due to stalls, saturating

Behaviour:
- Reset (synchronous, active-high): all ex_* outputs 0, ex_valid=0, stall_count=0. Reset overrides flush/stall. During reset stall is forced 0.
- hazard (combinational) = id_valid & ex_valid & ex_MemRead & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- stall = hazard & ~flush & ~reset.
- Each rising edge, priority order:
  1. reset -> clear as above.
  2. flush -> bubble: ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUOp = 0. Data/address fields are don't-care (implementation clears them to 0). stall_count unchanged.
  3. hazard -> bubble as in 2. stall_count += 1, saturating at all-ones.
  4. else -> load all ex_* from id_*. ex_valid=id_valid. If id_valid=0, control fields load as 0.
- Bubbles never assert RegWrite/MemRead/MemWrite, so forwarding sees no write from a bubble.
- Load-use costs exactly one bubble. On the next cycle ex_MemRead=0 (bubble), so hazard deasserts and the held instruction proceeds.
- Back-to-back load then dependent load: each dependency costs one bubble independently.
- rd=x0 never causes a stall.
- flush and hazard in the same cycle: flush wins. stall=0 and no count increment.
- Latency: ID to EX is one cycle when there is no stall.

Test Plan:
- Reset: assert reset 2 cycles with id_valid=1, id_RegWrite=1 -> all ex_* = 0, stall=0, stall_count=0. Deassert -> next edge loads ID fields.
- Pass-through: id_rs1=3, id_rs2=4, id_rd=5, id_rd1=0x11, id_imm=0xFFFFFFF0, id_RegWrite=1 -> after one edge ex_rs1=3, ex_rs2=4, ex_rd=5, ex_rd1=0x11, ex_imm=0xFFFFFFF0, ex_valid=1.
- Load-use: lw x5 in EX (ex_MemRead=1, ex_rd=5), ID add with rs1=5 -> stall=1, next edge ex_valid=0, stall_count=1. Following edge loads the add (ex_rs1=5).
- No false stall: ex_MemRead=1, ex_rd=5, id_rs2=5, id_use_rs2=0 -> stall=0. ex_rd=0 with id_rs1=0 -> stall=0.
- Flush priority: hazard conditions present plus flush=1 -> stall=0, next edge ex_valid=0, ex_RegWrite=0, stall_count unchanged.
- Saturation: with CNT_W=4, force 17 consecutive load-use stalls -> stall_count holds 15.
